// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for the RV32 core. Each instruction is stepped
//   through FETCH -> DECODE -> EXEC -> WB. Every stage gets a one-cycle
//   enable pulse and waits for its completion handshake. The module owns the
//   word-addressed architectural PC, applies execute-stage jump redirects at
//   the instruction boundary, counts retired instructions and runs a
//   per-stage watchdog.
//
// Ports
//   clk, rstn            clock; synchronous active-low reset
//   start                restart from PC_RESET (only in IDLE/HALTED/ERROR)
//   halt_req             stop at the next instruction boundary
//   fetch_en/fetch_done  fetch request pulse / completion
//   decode_en/decode_done decode request pulse / completion
//   exec_en/exec_done    execute request pulse / completion
//   is_jump, jump_dest   redirect info, valid together with exec_done
//   wb_en/wb_done        write-back request pulse / completion
//   pc                   PC of the instruction in flight
//   retired              completed-instruction count (wraps)
//   busy/halted/error    status levels (all registered)
// ---------------------------------------------------------------------------
module core_sequencer #(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter logic [15:0] TIMEOUT  = 16'd1024,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             halt_req,
  output logic             fetch_en,
  input  logic             fetch_done,
  output logic             decode_en,
  input  logic             decode_done,
  output logic             exec_en,
  input  logic             exec_done,
  input  logic             is_jump,
  input  logic [31:0]      jump_dest,
  output logic             wb_en,
  input  logic             wb_done,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic             busy,
  output logic             halted,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t           state_reg, state_next;
  // Stage enables indexed by stage: 0 fetch, 1 decode, 2 exec, 3 wb.
  logic [3:0]       en_reg, en_next;
  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic             jump_reg, jump_next;
  logic [31:0]      dest_reg, dest_next;
  logic             halt_pend_reg, halt_pend_next;
  logic [15:0]      wd_reg, wd_next;
  logic             busy_reg, busy_next;
  logic             halted_reg, halted_next;
  logic             error_reg, error_next;

  logic [3:0]       done_vec;
  logic             in_stage;
  logic [1:0]       stage_sel;
  logic             wd_expired;

  assign done_vec = {wb_done, exec_done, decode_done, fetch_done};

  // The counter holds the number of wait cycles already spent; expiry fires
  // on the wait cycle that would bring it to TIMEOUT. A done in that same
  // cycle is checked first and therefore wins.
  assign wd_expired = (TIMEOUT != 16'd0) &&
                      (({1'b0, wd_reg} + 17'd1) >= {1'b0, TIMEOUT});

  always_comb begin
    state_next     = state_reg;
    en_next        = 4'b0000;
    pc_next        = pc_reg;
    retired_next   = retired_reg;
    jump_next      = jump_reg;
    dest_next      = dest_reg;
    halt_pend_next = halt_pend_reg;
    wd_next        = wd_reg;
    in_stage       = 1'b0;
    stage_sel      = 2'd0;

    unique case (state_reg)
      S_FETCH:  begin in_stage = 1'b1; stage_sel = 2'd0; end
      S_DECODE: begin in_stage = 1'b1; stage_sel = 2'd1; end
      S_EXEC:   begin in_stage = 1'b1; stage_sel = 2'd2; end
      S_WB:     begin in_stage = 1'b1; stage_sel = 2'd3; end
      default:  ;
    endcase

    if (in_stage) begin
      if (halt_req) begin
        halt_pend_next = 1'b1;
      end
      // done is ignored while the enable pulse is still out.
      if (!en_reg[stage_sel]) begin
        if (done_vec[stage_sel]) begin
          wd_next = 16'd0;
          unique case (state_reg)
            S_FETCH: begin
              state_next = S_DECODE;
              en_next[1] = 1'b1;
            end
            S_DECODE: begin
              state_next = S_EXEC;
              en_next[2] = 1'b1;
            end
            S_EXEC: begin
              state_next = S_WB;
              en_next[3] = 1'b1;
              jump_next  = is_jump;
              dest_next  = jump_dest;
            end
            S_WB: begin
              pc_next      = jump_reg ? dest_reg : pc_reg + 32'd1;
              retired_next = retired_reg + CNT_W'(1);
              jump_next    = 1'b0;
              if (halt_req || halt_pend_reg) begin
                state_next     = S_HALTED;
                halt_pend_next = 1'b0;
              end else begin
                state_next = S_FETCH;
                en_next[0] = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (wd_expired) begin
          state_next     = S_ERROR;
          halt_pend_next = 1'b0;
          wd_next        = 16'd0;
        end else begin
          wd_next = wd_reg + 16'd1;
        end
      end
    end else if (state_reg == S_IDLE || state_reg == S_HALTED ||
                 state_reg == S_ERROR) begin
      if (start) begin
        state_next     = S_FETCH;
        en_next[0]     = 1'b1;
        pc_next        = PC_RESET;
        retired_next   = '0;
        jump_next      = 1'b0;
        halt_pend_next = 1'b0;
        wd_next        = 16'd0;
      end
    end else begin
      // Unused encoding: fall back to a safe idle.
      state_next = S_IDLE;
    end

    busy_next   = (state_next == S_FETCH) || (state_next == S_DECODE) ||
                  (state_next == S_EXEC)  || (state_next == S_WB);
    halted_next = (state_next == S_HALTED);
    error_next  = (state_next == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      en_reg        <= 4'b0000;
      pc_reg        <= PC_RESET;
      retired_reg   <= '0;
      jump_reg      <= 1'b0;
      dest_reg      <= 32'd0;
      halt_pend_reg <= 1'b0;
      wd_reg        <= 16'd0;
      busy_reg      <= 1'b0;
      halted_reg    <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      en_reg        <= en_next;
      pc_reg        <= pc_next;
      retired_reg   <= retired_next;
      jump_reg      <= jump_next;
      dest_reg      <= dest_next;
      halt_pend_reg <= halt_pend_next;
      wd_reg        <= wd_next;
      busy_reg      <= busy_next;
      halted_reg    <= halted_next;
      error_reg     <= error_next;
    end
  end

  assign fetch_en  = en_reg[0];
  assign decode_en = en_reg[1];
  assign exec_en   = en_reg[2];
  assign wb_en     = en_reg[3];
  assign pc        = pc_reg;
  assign retired   = retired_reg;
  assign busy      = busy_reg;
  assign halted    = halted_reg;
  assign error     = error_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_sequencer
//   Directed plus randomized bench for core_sequencer (TIMEOUT=4). Stage
//   handshakes are answered with configurable delays; a small instruction-
//   level model (next pc, retired count, halted flag, latency) supplies every
//   expected value.
// ---------------------------------------------------------------------------
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rstn, start, halt_req;
  logic        fetch_done, decode_done, exec_done, wb_done;
  logic        is_jump;
  logic [31:0] jump_dest;
  logic        fetch_en, decode_en, exec_en, wb_en;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        busy, halted, error;
  logic [3:0]  en_vec;

  always #5 clk = ~clk;

  core_sequencer #(
    .PC_RESET(32'd0),
    .TIMEOUT (16'd4),
    .CNT_W   (32)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .halt_req   (halt_req),
    .fetch_en   (fetch_en),
    .fetch_done (fetch_done),
    .decode_en  (decode_en),
    .decode_done(decode_done),
    .exec_en    (exec_en),
    .exec_done  (exec_done),
    .is_jump    (is_jump),
    .jump_dest  (jump_dest),
    .wb_en      (wb_en),
    .wb_done    (wb_done),
    .pc         (pc),
    .retired    (retired),
    .busy       (busy),
    .halted     (halted),
    .error      (error)
  );

  assign en_vec = {wb_en, exec_en, decode_en, fetch_en};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_fetch  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction-level reference state.
  logic [31:0] exp_pc, exp_ret;
  logic        exp_halt;

  // Per-instruction stimulus configuration.
  int          cfg_dly[4];
  bit          cfg_glitch[4];
  bit          cfg_jmp;
  logic [31:0] cfg_dest;
  int          cfg_halt_stage;
  bit          cfg_poke;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic set_done(input int s, input logic v);
    case (s)
      0: fetch_done  = v;
      1: decode_done = v;
      2: exec_done   = v;
      default: wb_done = v;
    endcase
  endtask

  task automatic cfg_plain(input int d);
    for (int s = 0; s < 4; s++) begin
      cfg_dly[s]    = d;
      cfg_glitch[s] = 1'b0;
    end
    cfg_jmp        = 1'b0;
    cfg_dest       = 32'd0;
    cfg_halt_stage = -1;
    cfg_poke       = 1'b0;
  endtask

  task automatic cfg_rand();
    for (int s = 0; s < 4; s++) begin
      cfg_dly[s]    = int'($urandom_range(0, 3));
      cfg_glitch[s] = ($urandom_range(0, 1) == 1);
    end
    cfg_jmp        = ($urandom_range(0, 3) == 0);
    cfg_dest       = $urandom;
    cfg_halt_stage = -1;
    cfg_poke       = ($urandom_range(0, 1) == 1);
  endtask

  // Drive one stage: wait for its enable, optionally glitch done during the
  // enable cycle, hold done low for cfg_dly wait cycles, then pulse done.
  task automatic stage(input int s);
    int         n;
    logic [3:0] onehot;
    onehot = 4'b0001 << s;
    n = 0;
    while (en_vec[s] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1("en_seen", en_vec[s], 1'b1);
    chk32("en_onehot", {28'd0, en_vec}, {28'd0, onehot});
    chk32("pc_stage", pc, exp_pc);
    chk1("busy_stage", busy, 1'b1);
    if (s == 0) t_fetch = cyc;
    set_done(s, cfg_glitch[s]);
    @(negedge clk);
    for (int k = 0; k < cfg_dly[s]; k++) begin
      chk32("en_pulse", {28'd0, en_vec}, 32'd0);
      chk32("pc_hold", pc, exp_pc);
      set_done(s, 1'b0);
      halt_req = (cfg_halt_stage == s) && (k == 0);
      start    = cfg_poke && (k == 0);
      @(negedge clk);
    end
    chk32("en_pulse", {28'd0, en_vec}, 32'd0);
    halt_req = 1'b0;
    start    = 1'b0;
    set_done(s, 1'b1);
    if (s == 2) begin
      is_jump   = cfg_jmp;
      jump_dest = cfg_dest;
    end
    @(negedge clk);
    set_done(s, 1'b0);
    // Garbage outside the valid window must not be latched.
    is_jump   = ($urandom_range(0, 1) == 1);
    jump_dest = $urandom;
  endtask

  task automatic run_instr();
    int lat;
    lat = 8;
    for (int s = 0; s < 4; s++) begin
      lat += cfg_dly[s];
      stage(s);
    end
    exp_pc   = cfg_jmp ? cfg_dest : exp_pc + 32'd1;
    exp_ret  = exp_ret + 32'd1;
    exp_halt = (cfg_halt_stage >= 0);
    chk32("pc_next", pc, exp_pc);
    chk32("retired", retired, exp_ret);
    chk1("halted", halted, exp_halt);
    chk1("busy_after", busy, !exp_halt);
    chk1("fetch_next", fetch_en, !exp_halt);
    chk1("error_low", error, 1'b0);
    chk32("latency", 32'(cyc - t_fetch), 32'(lat));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    exp_pc   = 32'd0;
    exp_ret  = 32'd0;
    exp_halt = 1'b0;
    chk1("start_fetch", fetch_en, 1'b1);
    chk32("start_pc", pc, exp_pc);
    chk32("start_ret", retired, exp_ret);
    chk1("start_busy", busy, 1'b1);
    chk1("start_halted", halted, 1'b0);
    chk1("start_error", error, 1'b0);
  endtask

  initial begin
    int n;
    rstn = 1'b0; start = 1'b0; halt_req = 1'b0;
    fetch_done = 1'b0; decode_done = 1'b0; exec_done = 1'b0; wb_done = 1'b0;
    is_jump = 1'b0; jump_dest = 32'd0;
    exp_pc = 32'd0; exp_ret = 32'd0; exp_halt = 1'b0;
    cfg_plain(0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk32("rst_pc", pc, 32'd0);
    chk32("rst_ret", retired, 32'd0);
    chk32("rst_en", {28'd0, en_vec}, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_error", error, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk32("idle_en", {28'd0, en_vec}, 32'd0);

    // Minimum-latency sequential run: pc 0,1,2 -> 3, 8 cycles each.
    do_start();
    cfg_plain(0);
    for (int i = 0; i < 3; i++) run_instr();

    // pc 3,4 with random delays, then jump at pc=5 to 0x40.
    for (int i = 0; i < 2; i++) begin
      cfg_rand();
      cfg_jmp = 1'b0;
      run_instr();
    end
    cfg_plain(1); cfg_jmp = 1'b1; cfg_dest = 32'h40;
    run_instr();

    // Glitched decode done with a real done 3 cycles later; non-jump -> 0x41.
    cfg_plain(0); cfg_glitch[1] = 1'b1; cfg_dly[1] = 3;
    run_instr();

    // Jump to 7, then halt requested mid-EXEC at pc=7.
    cfg_plain(0); cfg_jmp = 1'b1; cfg_dest = 32'd7;
    run_instr();
    cfg_plain(0); cfg_dly[2] = 2; cfg_halt_stage = 2;
    run_instr();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk32("halt_no_en", {28'd0, en_vec}, 32'd0);
      chk1("halt_level", halted, 1'b1);
      chk32("halt_pc", pc, 32'd8);
    end

    // Restart and run randomized traffic.
    do_start();
    for (int i = 0; i < 24; i++) begin
      cfg_rand();
      run_instr();
    end

    // PC wrap: jump to 0xFFFFFFFF, then a sequential step wraps to 0.
    cfg_plain(0); cfg_jmp = 1'b1; cfg_dest = 32'hFFFF_FFFF;
    run_instr();
    cfg_plain(1);
    run_instr();

    // Watchdog: decode never completes.
    cfg_plain(0);
    stage(0);
    n = 0;
    while (decode_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1("wd_decode_en", decode_en, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("wd_wait_err", error, 1'b0);
      chk1("wd_wait_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk1("wd_error", error, 1'b1);
    chk1("wd_busy", busy, 1'b0);
    chk1("wd_halted", halted, 1'b0);
    chk32("wd_pc", pc, exp_pc);
    chk32("wd_ret", retired, exp_ret);
    repeat (5) @(negedge clk);
    chk32("wd_no_en", {28'd0, en_vec}, 32'd0);
    chk1("wd_error_hold", error, 1'b1);
    do_start();

    // Reset during WB at pc=0x10.
    cfg_plain(0); cfg_jmp = 1'b1; cfg_dest = 32'h10;
    run_instr();
    cfg_plain(0);
    stage(0); stage(1); stage(2);
    n = 0;
    while (wb_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1("rwb_en", wb_en, 1'b1);
    chk32("rwb_pc", pc, 32'h10);
    @(negedge clk);
    rstn    = 1'b0;
    wb_done = 1'b1;
    @(negedge clk);
    rstn    = 1'b1;
    wb_done = 1'b0;
    exp_pc  = 32'd0;
    exp_ret = 32'd0;
    chk32("rwb_pc_rst", pc, exp_pc);
    chk32("rwb_ret_rst", retired, exp_ret);
    chk32("rwb_en_rst", {28'd0, en_vec}, 32'd0);
    chk1("rwb_busy", busy, 1'b0);
    chk1("rwb_halted", halted, 1'b0);
    chk1("rwb_error", error, 1'b0);

    // halt_req in IDLE is ignored: the next instruction does not halt.
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    @(negedge clk);
    chk1("idle_halt_ign", halted, 1'b0);
    chk1("idle_halt_busy", busy, 1'b0);
    do_start();
    cfg_plain(1);
    run_instr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle (non-pipelined) control FSM for the RV32 core.
- Steps each instruction through fetch -> decode -> execute -> write-back using one-cycle enable pulses and completion handshakes.
- Owns the architectural PC (word-addressed; sequential next PC is pc+1) and applies jump redirects reported by the execute stage.
- Provides start/halt control, a retired-instruction counter and a per-stage watchdog.

Parameters:
- PC_RESET, 32'd0, PC value loaded at reset and on start.
- TIMEOUT, 16'd1024, maximum wait cycles per stage before error; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  begin execution from PC_RESET (honoured only in IDLE/HALTED/ERROR).
- halt_req  in  1  stop at the next instruction boundary.
- fetch_en  out  1  one-cycle fetch request.
- fetch_done  in  1  fetch completed.
- decode_en  out  1  one-cycle decode request.
- decode_done  in  1  decode completed.
- exec_en  out  1  one-cycle execute request (drives execute.enabled).
- exec_done  in  1  execute completed (execute.completed).
- is_jump  in  1  execute redirect flag, valid with exec_done.
- jump_dest  in  32  execute redirect target, valid with exec_done.
- wb_en  out  1  one-cycle register/CSR write-back request.
- wb_done  in  1  write-back completed.
- pc  out  32  PC of the instruction in flight.
- retired  out  CNT_W  count of completed instructions.
- busy  out  1  high in any stage state.
- halted  out  1  high in HALTED.
- error  out  1  high in ERROR (watchdog expiry).

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED, ERROR. All outputs are registered.
- Reset (rstn=0 at posedge):
  - state=IDLE, pc=PC_RESET, retired=0.
  - All *_en=0; busy, halted, error = 0.
  - Jump latches and watchdog cleared.
  - Reset mid-instruction abandons it with no PC update and no retire.
- IDLE/HALTED/ERROR + start=1: pc<=PC_RESET, retired<=0, error<=0, go to FETCH.
- Stage entry:
  - The cycle after entering a stage state, that stage's *_en is 1 for exactly one cycle, then 0.
  - The matching *_done is sampled only in cycles where *_en=0. A done asserted in the same cycle as en is ignored, which matches execute's completed & !enabled gating.
- Transitions on done:
  - FETCH -> DECODE.
  - DECODE -> EXEC.
  - EXEC -> WB, latching is_jump and jump_dest at that edge.
  - WB -> boundary.
- Boundary (the wb_done edge):
  - pc <= latched is_jump ? latched jump_dest : pc+1 (32-bit, wraps 32'hFFFFFFFF -> 0).
  - retired <= retired+1 (wraps modulo 2^CNT_W).
  - If halt_req=1 (sampled this edge or pending), go to HALTED; otherwise go to FETCH.
- halt_req:
  - Asserted at any time, it is latched as pending until the boundary; the instruction in flight always completes.
  - In IDLE it is ignored.
  - Pending is cleared on entry to HALTED.
- start while busy is ignored.
- Watchdog:
  - Counter resets on each stage entry and increments while waiting for done.
  - When it reaches TIMEOUT with done still low, go to ERROR: error=1, busy=0, pc held at the faulting instruction, retired unchanged.
  - A done in the same cycle as the counter reaching TIMEOUT wins over the timeout.
- Output levels:
  - busy=1 in FETCH/DECODE/EXEC/WB.
  - halted=1 only in HALTED.
  - pc is stable for the whole instruction.
- Minimum latency per instruction with each done arriving one cycle after its en: 8 cycles.

Test Plan:
- Reset then start, with every done returned 1 cycle after its en and is_jump=0 -> pc steps 0,1,2,3 every 8 cycles; retired=3 after 24 cycles; each *_en is a single-cycle pulse.
- exec_done=1 with is_jump=1, jump_dest=0x40 at pc=5 -> after wb_done, pc=0x40 and retired increments by 1; a later non-jump -> pc=0x41.
- Done held high during the en cycle only (glitch) -> ignored, FSM stays waiting; a real done 3 cycles later -> advances.
- halt_req pulsed mid-EXEC at pc=7 -> instruction completes, pc=8, halted=1, no further fetch_en; start -> pc=PC_RESET, retired=0, fetch resumes.
- TIMEOUT=4 and decode_done never asserted -> error=1 exactly 4 wait cycles after decode_en, pc unchanged; start clears error.
- rstn low during WB at pc=0x10 -> next cycle pc=PC_RESET, state IDLE, retired=0, all *_en=0; pc=32'hFFFFFFFF non-jump -> wraps to 0.
